ov7670_pixel_capture: RTL

Downstream neighbour of the camera register-init sequencer. Once the OV7670 has been configured, this block takes the raw camera bus (VSYNC, HREF, D[7:0]) on the pixel clock and pairs each two-byte sequence into one RGB565 pixel. It presents the pixels on a valid/ready stream, marks frame and line boundaries, and reports overrun and geometry errors. The consumer is the frame-buffer writer (PSRAM path).

---
 rtl/camera_capture_pkg.sv | 19 +
 rtl/cam_sync_edge.sv | 41 ++++
 rtl/ov7670_pixel_capture.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/camera_capture_pkg.sv
// Shared types and constants for the OV7670 capture path.
package camera_capture_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, FRAME, LINE} CAPTURE_STATES;

    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    localparam int RGB_R_W = 5;
    localparam int RGB_G_W = 6;
    localparam int RGB_B_W = 5;
    localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

    // The camera sends the byte holding red and upper green first.
    function automatic logic [PIX_W-1:0] pack_rgb565(input logic [7:0] first, input logic [7:0] second);
        return {first, second};
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers the raw camera bus once and derives VSYNC/HREF edge pulses from the registered copies.
module cam_sync_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       vsync,
    output logic       href,
    output logic [7:0] data,
    output logic       vsync_rise,
    output logic       vsync_fall,
    output logic       href_rise,
    output logic       href_fall
);

    logic vsync_prev;
    logic href_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= 8'h00;
            vsync_prev <= 1'b0;
            href_prev  <= 1'b0;
        end else begin
            vsync      <= cam_vsync;
            href       <= cam_href;
            data       <= cam_data;
            vsync_prev <= vsync;
            href_prev  <= href;
        end
    end

    assign vsync_rise = vsync & ~vsync_prev;
    assign vsync_fall = ~vsync & vsync_prev;
    assign href_rise  = href & ~href_prev;
    assign href_fall  = ~href & href_prev;

endmodule

// File: rtl/ov7670_pixel_capture.sv
// Pairs OV7670 bytes into RGB565 pixels on a one-entry valid/ready output register,
// tracking frame/line position and flagging overrun and geometry errors.
module ov7670_pixel_capture
    import camera_capture_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          cam_vsync,
    input  logic                          cam_href,
    input  logic [7:0]                    cam_data,
    output logic [PIX_W-1:0]              pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          pix_sof,
    output logic                          pix_eol,
    output logic                          frame_done,
    output logic [$clog2(V_ACTIVE+1)-1:0] line_cnt,
    output logic [15:0]                   frame_cnt,
    input  logic                          err_clr,
    output logic                          err_overrun,
    output logic                          err_geometry
);

    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int BW = $clog2(2 * H_ACTIVE + 2);
    localparam logic [LW-1:0] LINES_FULL = LW'(V_ACTIVE);
    localparam logic [XW-1:0] X_SAT      = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);
    localparam logic [BW-1:0] BYTES_LINE = BW'(2 * H_ACTIVE);
    localparam logic [BW-1:0] BYTES_SAT  = BW'(2 * H_ACTIVE + 1);

    logic       vsync, href, vsync_rise, vsync_fall, href_rise, href_fall;
    logic [7:0] data;

    cam_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .href_rise  (href_rise),
        .href_fall  (href_fall)
    );

    CAPTURE_STATES state, state_next;
    logic          frame_start, frame_end, line_end, byte_take, geom_set;

    logic [7:0]    first_byte;
    logic          byte_phase;
    logic [XW-1:0] x_cnt;
    logic [BW-1:0] byte_cnt;
    logic          sof_pending;
    logic          form_pixel, load_pixel, drop_pixel;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A VSYNC rise always beats a same-cycle HREF rise, so a line never starts in blanking.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        line_end    = 1'b0;
        byte_take   = 1'b0;
        geom_set    = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = WAIT_FRAME;
                WAIT_FRAME: begin
                    if (vsync_fall) begin
                        frame_start = 1'b1;
                        state_next  = FRAME;
                    end
                end
                FRAME: begin
                    if (vsync_rise) begin
                        frame_end  = 1'b1;
                        geom_set   = (line_cnt != LINES_FULL);
                        state_next = WAIT_FRAME;
                    end else if (href_rise && !vsync) begin
                        byte_take  = 1'b1;
                        state_next = LINE;
                    end
                end
                LINE: begin
                    if (vsync_rise) begin
                        frame_end  = 1'b1;
                        geom_set   = 1'b1;
                        state_next = WAIT_FRAME;
                    end else if (href_fall) begin
                        line_end   = 1'b1;
                        geom_set   = (byte_cnt != BYTES_LINE);
                        state_next = FRAME;
                    end else if (href) begin
                        byte_take  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign form_pixel = byte_take && byte_phase;
    assign load_pixel = form_pixel && (!pix_valid || pix_ready);
    assign drop_pixel = form_pixel && !load_pixel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            frame_done  <= 1'b0;
            line_cnt    <= '0;
            frame_cnt   <= 16'd0;
            first_byte  <= 8'h00;
            byte_phase  <= 1'b0;
            x_cnt       <= '0;
            byte_cnt    <= '0;
            sof_pending <= 1'b0;
        end else if (!enable) begin
            pix_valid   <= 1'b0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            frame_done  <= 1'b0;
            line_cnt    <= '0;
            byte_phase  <= 1'b0;
            x_cnt       <= '0;
            byte_cnt    <= '0;
            sof_pending <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_start) begin
                line_cnt    <= '0;
                sof_pending <= 1'b1;
            end
            if (frame_end) frame_cnt <= frame_cnt + 16'd1;
            if (line_end && line_cnt != LINES_FULL) line_cnt <= line_cnt + 1'b1;
            if (frame_start || frame_end || line_end) begin
                byte_phase <= 1'b0;
                x_cnt      <= '0;
                byte_cnt   <= '0;
            end
            if (byte_take) begin
                if (byte_cnt != BYTES_SAT) byte_cnt <= byte_cnt + 1'b1;
                byte_phase <= ~byte_phase;
                if (!byte_phase) first_byte <= data;
            end
            // x and the start-of-frame marker advance even when the pixel itself is dropped.
            if (form_pixel) begin
                sof_pending <= 1'b0;
                if (x_cnt != X_SAT) x_cnt <= x_cnt + 1'b1;
            end
            if (load_pixel) begin
                pix_data  <= pack_rgb565(first_byte, data);
                pix_valid <= 1'b1;
                pix_sof   <= sof_pending;
                pix_eol   <= (x_cnt == X_LAST);
            end else if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
                pix_sof   <= 1'b0;
                pix_eol   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_overrun  <= 1'b0;
            err_geometry <= 1'b0;
        end else begin
            if (drop_pixel)   err_overrun <= 1'b1;
            else if (err_clr) err_overrun <= 1'b0;
            if (geom_set)     err_geometry <= 1'b1;
            else if (err_clr) err_geometry <= 1'b0;
        end
    end

endmodule
